// File: rtl/pulsador_mantenimiento.sv
// Pushbutton front end for the maintenance monitor.
// Synchronises and debounces one raw button. A short press produces a single-cycle
// M pulse and bumps press_count; a long press produces a RST_PULSE-cycle rst_manual
// pulse and never M. Reset is asynchronous, active-low, on port rst.
module pulsador_mantenimiento #(
  parameter int DEB_CYCLES  = 4,
  parameter int LONG_CYCLES = 50,
  parameter int RST_PULSE   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_raw,
  output logic       M,
  output logic       rst_manual,
  output logic       btn_level,
  output logic [7:0] press_count
);

  localparam int DW = (DEB_CYCLES  > 1) ? $clog2(DEB_CYCLES)  : 1;
  localparam int HW = (LONG_CYCLES > 1) ? $clog2(LONG_CYCLES) : 1;
  localparam int PW = (RST_PULSE   > 1) ? $clog2(RST_PULSE)   : 1;

  localparam logic [DW-1:0] DEB_LAST   = DW'(DEB_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST  = HW'(LONG_CYCLES - 1);
  localparam logic [PW-1:0] PULSE_LAST = PW'(RST_PULSE - 1);

  typedef enum logic [2:0] {
    IDLE,
    DEB_PRESS,
    PRESSED,
    LONG_HELD,
    DEB_RELEASE
  } state_t;

  state_t        state;
  logic          btn_m;
  logic          btn_s;
  logic [DW-1:0] deb_cnt;
  logic [HW-1:0] hold_cnt;
  logic [PW-1:0] pulse_cnt;
  logic          long_f;
  logic          start_pulse;

  // The hold threshold reached while the button is still down; a release seen in
  // the same cycle takes priority, so btn_s is part of the condition.
  assign start_pulse = (state == PRESSED) && btn_s && (hold_cnt == HOLD_LAST);

  // Two-flop synchroniser for the asynchronous button input.
  // NOTE: sequential state always uses non-blocking assignments so every flop
  // samples the pre-edge value of the others; blocking here would collapse the
  // two stages into one.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      btn_m <= 1'b0;
      btn_s <= 1'b0;
    end else begin
      btn_m <= btn_raw;
      btn_s <= btn_m;
    end
  end

  // Debounce/press-classification FSM with registered M, btn_level and press_count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      deb_cnt     <= '0;
      hold_cnt    <= '0;
      long_f      <= 1'b0;
      M           <= 1'b0;
      btn_level   <= 1'b0;
      press_count <= 8'd0;
    end else begin
      // NOTE: M defaults low every cycle so any assertion below lasts exactly one cycle.
      M <= 1'b0;
      unique case (state)
        IDLE: begin
          if (btn_s) begin
            state   <= DEB_PRESS;
            deb_cnt <= '0;
          end
        end
        DEB_PRESS: begin
          if (!btn_s) begin
            state <= IDLE;
          end else if (deb_cnt == DEB_LAST) begin
            state     <= PRESSED;
            hold_cnt  <= '0;
            btn_level <= 1'b1;
          end else begin
            deb_cnt <= deb_cnt + DW'(1);
          end
        end
        PRESSED: begin
          if (!btn_s) begin
            state   <= DEB_RELEASE;
            long_f  <= 1'b0;
            deb_cnt <= '0;
          end else if (start_pulse) begin
            state <= LONG_HELD;
          end else if (hold_cnt != HOLD_LAST) begin
            hold_cnt <= hold_cnt + HW'(1);
          end
        end
        LONG_HELD: begin
          if (!btn_s) begin
            state   <= DEB_RELEASE;
            long_f  <= 1'b1;
            deb_cnt <= '0;
          end
        end
        DEB_RELEASE: begin
          if (btn_s) begin
            state <= long_f ? LONG_HELD : PRESSED;
          end else if (deb_cnt == DEB_LAST) begin
            state     <= IDLE;
            btn_level <= 1'b0;
            if (!long_f) begin
              M           <= 1'b1;
              press_count <= press_count + 8'd1;
            end
          end else begin
            deb_cnt <= deb_cnt + DW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // rst_manual pulse timer: fixed width once started, independent of the button.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rst_manual <= 1'b0;
      pulse_cnt  <= '0;
    end else if (start_pulse) begin
      rst_manual <= 1'b1;
      pulse_cnt  <= '0;
    end else if (rst_manual) begin
      if (pulse_cnt == PULSE_LAST) begin
        rst_manual <= 1'b0;
      end else begin
        pulse_cnt <= pulse_cnt + PW'(1);
      end
    end
  end

endmodule

// File: tb/tb_pulsador_mantenimiento.sv
// Self-checking bench for pulsador_mantenimiento: a table of press lengths with
// expected outcomes, then hand-written sequences for timing, bounce, reset and wrap.
module tb_pulsador_mantenimiento;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_raw;
  logic       M;
  logic       rst_manual;
  logic       btn_level;
  logic [7:0] press_count;

  int total = 0;
  int bad   = 0;

  // Output monitor, sampled on the falling edge.
  int cyc = 0;
  int m_high, m_rises, m_rise_cyc;
  int r_high, r_rises, r_rise_cyc;
  int lvl_seen, lvl_falls, lvl_rise_cyc, lvl_fall_cyc;
  int both_high;
  bit m_prev = 1'b0, r_prev = 1'b0, l_prev = 1'b0;

  typedef struct {
    int press_len;
    int gap;
    int exp_m;       // M pulses (and M-high cycles) expected
    int exp_r;       // rst_manual-high cycles expected
    int exp_lvl;     // btn_level seen high at all
    int exp_inc;     // press_count increment
  } vec_t;

  vec_t vecs[7];
  int   exp_count;

  pulsador_mantenimiento dut (
    .clk        (clk),
    .rst        (rst),
    .btn_raw    (btn_raw),
    .M          (M),
    .rst_manual (rst_manual),
    .btn_level  (btn_level),
    .press_count(press_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (M) begin
      m_high = m_high + 1;
      if (!m_prev) begin m_rises = m_rises + 1; m_rise_cyc = cyc; end
    end
    if (rst_manual) begin
      r_high = r_high + 1;
      if (!r_prev) begin r_rises = r_rises + 1; r_rise_cyc = cyc; end
    end
    if (btn_level) lvl_seen = 1;
    if (btn_level && !l_prev) lvl_rise_cyc = cyc;
    if (!btn_level && l_prev) begin lvl_falls = lvl_falls + 1; lvl_fall_cyc = cyc; end
    if (M && rst_manual) both_high = both_high + 1;
    m_prev = M;
    r_prev = rst_manual;
    l_prev = btn_level;
  end

  task automatic check(input string name, input int actual, input int expected);
    total = total + 1;
    if (actual != expected) begin
      bad = bad + 1;
      $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic clear_mon();
    m_high = 0; m_rises = 0; m_rise_cyc = -1;
    r_high = 0; r_rises = 0; r_rise_cyc = -1;
    lvl_seen = 0; lvl_falls = 0; lvl_rise_cyc = -1; lvl_fall_cyc = -1;
    both_high = 0;
  endtask

  // btn_raw high for len sampled edges, then low for gap edges.
  task automatic press(input int len, input int gap);
    @(posedge clk); #1 btn_raw = 1'b1;
    repeat (len) @(posedge clk);
    #1 btn_raw = 1'b0;
    repeat (gap) @(posedge clk);
  endtask

  initial begin
    vecs[0] = '{press_len: 2,  gap: 20, exp_m: 0, exp_r: 0, exp_lvl: 0, exp_inc: 0};
    vecs[1] = '{press_len: 4,  gap: 20, exp_m: 0, exp_r: 0, exp_lvl: 0, exp_inc: 0};
    vecs[2] = '{press_len: 5,  gap: 20, exp_m: 1, exp_r: 0, exp_lvl: 1, exp_inc: 1};
    vecs[3] = '{press_len: 20, gap: 20, exp_m: 1, exp_r: 0, exp_lvl: 1, exp_inc: 1};
    vecs[4] = '{press_len: 54, gap: 20, exp_m: 1, exp_r: 0, exp_lvl: 1, exp_inc: 1};
    vecs[5] = '{press_len: 55, gap: 20, exp_m: 0, exp_r: 4, exp_lvl: 1, exp_inc: 0};
    vecs[6] = '{press_len: 80, gap: 20, exp_m: 0, exp_r: 4, exp_lvl: 1, exp_inc: 0};

    clear_mon();
    btn_raw = 1'b0;
    rst     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_M", int'(M), 0);
    check("reset_rst_manual", int'(rst_manual), 0);
    check("reset_btn_level", int'(btn_level), 0);
    check("reset_press_count", int'(press_count), 0);
    rst = 1'b1;
    repeat (2) @(posedge clk);

    // Table-driven press lengths, including debounce and long-press boundaries.
    exp_count = 0;
    foreach (vecs[i]) begin
      clear_mon();
      press(vecs[i].press_len, vecs[i].gap);
      exp_count = (exp_count + vecs[i].exp_inc) % 256;
      check($sformatf("v%0d_len%0d_m_pulses", i, vecs[i].press_len), m_rises, vecs[i].exp_m);
      check($sformatf("v%0d_len%0d_m_cycles", i, vecs[i].press_len), m_high, vecs[i].exp_m);
      check($sformatf("v%0d_len%0d_rst_cycles", i, vecs[i].press_len), r_high, vecs[i].exp_r);
      check($sformatf("v%0d_len%0d_level_seen", i, vecs[i].press_len), lvl_seen, vecs[i].exp_lvl);
      check($sformatf("v%0d_len%0d_press_count", i, vecs[i].press_len), int'(press_count), exp_count);
      check($sformatf("v%0d_len%0d_level_end", i, vecs[i].press_len), int'(btn_level), 0);
      check($sformatf("v%0d_len%0d_overlap", i, vecs[i].press_len), both_high, 0);
    end

    // Short press: M coincides with btn_level falling.
    clear_mon();
    press(20, 20);
    exp_count = (exp_count + 1) % 256;
    check("short_m_at_level_fall", m_rise_cyc, lvl_fall_cyc);
    check("short_press_count", int'(press_count), exp_count);

    // Long press: rst_manual rises LONG_CYCLES after btn_level, one contiguous pulse.
    clear_mon();
    press(80, 20);
    check("long_rst_delay", r_rise_cyc - lvl_rise_cyc, 50);
    check("long_rst_rises", r_rises, 1);
    check("long_no_m", m_rises, 0);
    check("long_press_count", int'(press_count), exp_count);

    // Release bounce 0,0,1,1,0: one M, btn_level drops once.
    clear_mon();
    @(posedge clk); #1 btn_raw = 1'b1;
    repeat (20) @(posedge clk);
    #1 btn_raw = 1'b0;
    repeat (2) @(posedge clk);
    #1 btn_raw = 1'b1;
    repeat (2) @(posedge clk);
    #1 btn_raw = 1'b0;
    repeat (20) @(posedge clk);
    exp_count = (exp_count + 1) % 256;
    check("bounce_m_pulses", m_rises, 1);
    check("bounce_level_falls", lvl_falls, 1);
    check("bounce_m_at_level_fall", m_rise_cyc, lvl_fall_cyc);
    check("bounce_press_count", int'(press_count), exp_count);

    // Reset during PRESSED.
    begin
      int n = 0;
      @(posedge clk); #1 btn_raw = 1'b1;
      while (!btn_level && n < 50) begin @(negedge clk); n++; end
      check("rstp_reached_pressed", int'(btn_level), 1);
      repeat (5) @(negedge clk);
      #1 rst = 1'b0;
      #1;
      check("rstp_level", int'(btn_level), 0);
      check("rstp_M", int'(M), 0);
      check("rstp_press_count", int'(press_count), 0);
      btn_raw = 1'b0;
      repeat (3) @(posedge clk);
      clear_mon();
      #1 rst = 1'b1;
      repeat (30) @(posedge clk);
      check("rstp_no_m_after", m_rises, 0);
      check("rstp_no_level_after", lvl_seen, 0);
      exp_count = 0;
    end

    // Reset while rst_manual is high.
    begin
      int n = 0;
      @(posedge clk); #1 btn_raw = 1'b1;
      while (!rst_manual && n < 120) begin @(negedge clk); n++; end
      check("rstr_pulse_started", int'(rst_manual), 1);
      @(negedge clk);
      #1 rst = 1'b0;
      #1;
      check("rstr_rst_manual_cut", int'(rst_manual), 0);
      check("rstr_level", int'(btn_level), 0);
      btn_raw = 1'b0;
      repeat (3) @(posedge clk);
      clear_mon();
      #1 rst = 1'b1;
      repeat (30) @(posedge clk);
      check("rstr_no_pulse_after", r_high, 0);
      check("rstr_no_m_after", m_rises, 0);
      check("rstr_press_count", int'(press_count), 0);
    end

    // 256 short presses: press_count wraps back to zero.
    clear_mon();
    for (int k = 0; k < 255; k++) press(10, 10);
    check("wrap_count_255", int'(press_count), 255);
    press(10, 10);
    check("wrap_count_0", int'(press_count), 0);
    check("wrap_m_pulses", m_rises, 256);
    check("wrap_m_cycles", m_high, 256);
    check("wrap_no_rst", r_high, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
